proc_seq_ctrl: RTL

- Sequencer inside top_processor that runs one vector job after start_i.
- Each job streams op, A and B memories through an internal ALU and writes results to OUT memory.
- Drives all memory read/write ports during a run; the host path is muxed off via busy_o.
- Signals completion on done_o, the level the host polls.

---
 rtl/proc_seq_ctrl_pkg.sv | 15 +
 rtl/proc_seq_ctrl_if.sv | 20 ++
 rtl/proc_seq_ctrl_alu.sv | 25 ++
 rtl/proc_seq_ctrl.sv | 68 ++++++
 4 files changed

// File: rtl/proc_seq_ctrl_pkg.sv
// proc_seq_ctrl_pkg: widths, opcode constants and sequencer state encoding
package proc_seq_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int OP_WIDTH = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [OP_WIDTH-1:0] OP_ADD = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_MUL = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_PASSA = 4'd6;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/proc_seq_ctrl_if.sv
// proc_seq_ctrl_if: memory bus (shared A/B/OP read port, OUT write port); master = sequencer, slave = memories
interface proc_seq_ctrl_if;
  import proc_seq_ctrl_pkg::*;
  logic [ADDR_WIDTH-1:0] mem_raddr_o;
  logic mem_ren_o;
  logic [DATA_WIDTH-1:0] a_rdata_i;
  logic [DATA_WIDTH-1:0] b_rdata_i;
  logic [OP_WIDTH-1:0] op_rdata_i;
  logic [ADDR_WIDTH-1:0] out_waddr_o;
  logic [DATA_WIDTH-1:0] out_wdata_o;
  logic out_we_o;
  modport master (
    output mem_raddr_o, mem_ren_o, out_waddr_o, out_wdata_o, out_we_o,
    input a_rdata_i, b_rdata_i, op_rdata_i
  );
  modport slave (
    input mem_raddr_o, mem_ren_o, out_waddr_o, out_wdata_o, out_we_o,
    output a_rdata_i, b_rdata_i, op_rdata_i
  );
endinterface

// File: rtl/proc_seq_ctrl_alu.sv
// proc_alu: combinational ALU (op, a, b -> y, illegal); unknown opcodes pass a and flag illegal
module proc_alu
  import proc_seq_ctrl_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  illegal
);
  always_comb begin
    illegal = 1'b0;
    y = a;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR: y = a | b;
      OP_XOR: y = a ^ b;
      OP_MUL: y = a * b;
      OP_PASSA: y = a;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: vector job sequencer (CLK/RST, start_i/len_i launch, busy_o/done_o/err_o status, mem bus master)
module proc_seq_ctrl
  import proc_seq_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start_i,
  input  logic [ADDR_WIDTH:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  proc_seq_ctrl_if.master     mem
);
  state_t state, state_n;
  logic start_d, launch, last_rd, p1_v, illegal;
  logic [ADDR_WIDTH:0] len_q, rd_cnt;
  logic [ADDR_WIDTH-1:0] p1_tag;
  logic [DATA_WIDTH-1:0] alu_y;
  proc_alu u_alu (
    .op(mem.op_rdata_i),
    .a(mem.a_rdata_i),
    .b(mem.b_rdata_i),
    .y(alu_y),
    .illegal(illegal)
  );
  assign launch = (state == S_IDLE) && start_i && !start_d;
  assign last_rd = rd_cnt == len_q - 1'b1;
  assign busy_o = (state == S_RUN) || (state == S_DRAIN);
  assign done_o = state == S_DONE;
  assign mem.mem_ren_o = state == S_RUN;
  assign mem.mem_raddr_o = (state == S_RUN) ? rd_cnt[ADDR_WIDTH-1:0] : '0;
  // DRAIN ends when the write on the bus is the last one: nothing left in the read stage
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = launch ? ((len_i == '0) ? S_DONE : S_RUN) : S_IDLE;
      S_RUN: state_n = last_rd ? S_DRAIN : S_RUN;
      S_DRAIN: state_n = (mem.out_we_o && !p1_v) ? S_DONE : S_DRAIN;
      S_DONE: state_n = start_i ? S_DONE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      start_d <= 1'b0;
      len_q <= '0;
      rd_cnt <= '0;
      p1_v <= 1'b0;
      p1_tag <= '0;
      err_o <= 1'b0;
      mem.out_we_o <= 1'b0;
      mem.out_waddr_o <= '0;
      mem.out_wdata_o <= '0;
    end else begin
      state <= state_n;
      start_d <= start_i;
      len_q <= launch ? len_i : len_q;
      rd_cnt <= launch ? '0 : (mem.mem_ren_o ? rd_cnt + 1'b1 : rd_cnt);
      p1_v <= mem.mem_ren_o;
      p1_tag <= mem.mem_raddr_o;
      mem.out_we_o <= p1_v;
      mem.out_waddr_o <= p1_tag;
      mem.out_wdata_o <= p1_v ? alu_y : '0;
      err_o <= launch ? 1'b0 : (err_o | (p1_v & illegal));
    end
  end
endmodule
